// File: rtl/lz77_pkg.sv
// Shared LZ77 constants, token layout and FSM state type for the encoder/decoder pair.
package lz77_pkg;

  localparam int unsigned BLOCK_LEN   = 4096;
  localparam int unsigned MAX_OFF     = 2047;
  localparam int unsigned MAX_LEN     = 31;
  localparam int unsigned MIN_MATCH   = 3;

  localparam int unsigned LEN_W       = 5;
  localparam int unsigned OFF_W       = 11;
  localparam int unsigned POS_W       = 13;
  localparam int unsigned ADDR_W      = 12;
  localparam int unsigned CAND_W      = 12;
  localparam int unsigned OFF_LO_BITS = 3;

  localparam logic [7:0] LIT_HDR = 8'h00;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } token_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEARCH,
    EMIT_A,
    EMIT_B
  } state_t;

  // Byte A carries the low offset bits above the length, byte B the high offset bits.
  function automatic token_t match_token(input logic [LEN_W-1:0] len,
                                         input logic [OFF_W-1:0] off);
    token_t t;
    t.a = {off[OFF_LO_BITS-1:0], len};
    t.b = off[OFF_W-1:OFF_LO_BITS];
    return t;
  endfunction

endpackage

// File: rtl/lz77_match_search.sv
// Serial brute-force longest-match scan: one byte comparison per cycle over offsets 1..min(pos, MAX_OFF).
module lz77_match_search
  import lz77_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              clear,
  input  logic [POS_W-1:0]  pos,
  input  logic [POS_W-1:0]  blk_len,
  input  logic [7:0]        byte_a,
  input  logic [7:0]        byte_b,
  output logic [ADDR_W-1:0] addr_a_c,
  output logic [ADDR_W-1:0] addr_b_c,
  output logic              done_c,
  output logic [LEN_W-1:0]  best_len,
  output logic [OFF_W-1:0]  best_off
);

  logic [CAND_W-1:0] off;
  logic [LEN_W-1:0]  k;
  logic [POS_W-1:0]  limit;
  logic [POS_W-1:0]  tail;
  logic              extend;

  // off==0 marks a fresh position; the first SEARCH cycle only arms offset 1.
  always_comb begin
    limit    = (pos > POS_W'(MAX_OFF)) ? POS_W'(MAX_OFF) : pos;
    tail     = pos + POS_W'(k);
    addr_b_c = tail[ADDR_W-1:0];
    addr_a_c = ADDR_W'(tail - POS_W'(off));
    extend   = (k < LEN_W'(MAX_LEN)) && (tail < blk_len) && (byte_a == byte_b);
    if (off == '0) begin
      done_c = (pos == '0);
    end else begin
      done_c = (POS_W'(off) > limit) || (best_len == LEN_W'(MAX_LEN));
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      off      <= '0;
      k        <= '0;
      best_len <= '0;
      best_off <= '0;
    end else if (run && !done_c) begin
      if (off == '0) begin
        off <= CAND_W'(1);
      end else if (extend) begin
        k <= k + LEN_W'(1);
      end else begin
        // Strict > keeps the smallest offset on equal lengths.
        if (k > best_len) begin
          best_len <= k;
          best_off <= off[OFF_W-1:0];
        end
        off <= off + CAND_W'(1);
        k   <= '0;
      end
    end
  end

endmodule

// File: rtl/lz77_encoder.sv
// LZ77 encoder: loads a block of up to BLOCK_LEN bytes, then emits two-byte literal/match tokens.
module lz77_encoder
  import lz77_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_data,
  input  logic       i_en,
  input  logic       i_last,
  output logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_en,
  input  logic       o_ready
);

  state_t            state;
  state_t            state_next;
  logic [POS_W-1:0]  blk_len;
  logic [POS_W-1:0]  blk_len_next;
  logic [POS_W-1:0]  pos;
  logic [POS_W-1:0]  pos_next;
  logic [7:0]        o_data_next;

  logic [7:0]        mem [BLOCK_LEN];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [7:0]        rd_a;
  logic [7:0]        rd_b;

  logic              accept;
  logic              run;
  logic              clear;
  logic              done;
  logic              is_match;
  logic [LEN_W-1:0]  best_len;
  logic [OFF_W-1:0]  best_off;
  token_t            tok;

  assign accept    = i_en && i_ready;
  assign run       = (state == SEARCH);
  // Outside SEARCH the second read port serves the literal byte at pos.
  assign rd_addr_b = run ? addr_b : pos[ADDR_W-1:0];
  assign rd_a      = mem[addr_a];
  assign rd_b      = mem[rd_addr_b];
  assign is_match  = (best_len >= LEN_W'(MIN_MATCH));

  lz77_match_search u_search (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .clear    (clear),
    .pos      (pos),
    .blk_len  (blk_len),
    .byte_a   (rd_a),
    .byte_b   (rd_b),
    .addr_a_c (addr_a),
    .addr_b_c (addr_b),
    .done_c   (done),
    .best_len (best_len),
    .best_off (best_off)
  );

  always_comb begin
    if (is_match) begin
      tok = match_token(best_len, best_off);
    end else begin
      tok.a = LIT_HDR;
      tok.b = rd_b;
    end
  end

  always_comb begin
    state_next   = state;
    blk_len_next = blk_len;
    pos_next     = pos;
    o_data_next  = o_data;
    wr_en        = 1'b0;
    wr_addr      = blk_len[ADDR_W-1:0];
    clear        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          wr_en        = 1'b1;
          wr_addr      = '0;
          blk_len_next = POS_W'(1);
          state_next   = i_last ? SEARCH : LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          wr_en        = 1'b1;
          blk_len_next = blk_len + POS_W'(1);
          if (i_last || (blk_len_next == POS_W'(BLOCK_LEN))) state_next = SEARCH;
        end
      end
      SEARCH: begin
        if (done) begin
          state_next  = EMIT_A;
          o_data_next = tok.a;
        end
      end
      EMIT_A: begin
        if (o_ready) begin
          state_next  = EMIT_B;
          o_data_next = tok.b;
        end
      end
      EMIT_B: begin
        if (o_ready) begin
          clear    = 1'b1;
          pos_next = pos + (is_match ? POS_W'(best_len) : POS_W'(1));
          if (pos_next < blk_len) begin
            state_next = SEARCH;
          end else begin
            state_next   = IDLE;
            blk_len_next = '0;
            pos_next     = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (rst) wr_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      blk_len <= '0;
      pos     <= '0;
      o_en    <= 1'b0;
      o_data  <= '0;
      i_ready <= 1'b0;
    end else begin
      state   <= state_next;
      blk_len <= blk_len_next;
      pos     <= pos_next;
      o_data  <= o_data_next;
      o_en    <= (state_next == EMIT_A) || (state_next == EMIT_B);
      i_ready <= (state_next == IDLE) || (state_next == LOAD);
    end
  end

  // Block buffer is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= i_data;
  end

endmodule

// File: tb/tb_lz77_encoder.sv
// Directed bench for lz77_encoder: hand-computed token streams, stall, reset and block-boundary cases.
module tb_lz77_encoder;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_data;
  logic       i_en;
  logic       i_last;
  logic       i_ready;
  logic [7:0] o_data;
  logic       o_en;
  logic       o_ready;

  int  n_cmp = 0;
  int  n_err = 0;
  bq_t got;
  bq_t exp_q;
  bq_t blk;

  lz77_encoder dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .i_en    (i_en),
    .i_last  (i_last),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_en    (o_en),
    .o_ready (o_ready)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got_v, exp_v);
    end
  endtask

  // Called at a negedge; each byte transfers on the posedge where i_ready is high.
  task automatic send_block(input bq_t d, input bit with_last);
    int guard;
    for (int n = 0; n < d.size(); n++) begin
      i_data = d[n];
      i_en   = 1'b1;
      i_last = with_last && (n == d.size() - 1);
      guard  = 0;
      while (!i_ready && guard < 1000) begin
        @(negedge clk);
        guard++;
      end
      if (!i_ready) begin
        check_val("send_timeout", i_ready, 1);
        i_en = 1'b0;
        i_last = 1'b0;
        return;
      end
      @(negedge clk);
    end
    i_en   = 1'b0;
    i_last = 1'b0;
    check_val("ready_drop", i_ready, 0);
  endtask

  task automatic collect(input int n, input int stall_at, input int limit);
    int         guard;
    logic [7:0] held;
    guard = 0;
    got   = {};
    while (got.size() < n && guard < limit) begin
      @(negedge clk);
      guard++;
      if (o_en && got.size() == stall_at) begin
        o_ready = 1'b0;
        held    = o_data;
        repeat (3) begin
          @(negedge clk);
          check_val("stall_en", o_en, 1);
          check_val("stall_data", o_data, held);
        end
      end
      o_ready = 1'b1;
      if (o_en) got.push_back(o_data);
    end
    @(negedge clk);
    o_ready = 1'b0;
    check_val("collect_count", got.size(), n);
    check_val("idle_ready", i_ready, 1);
    check_val("idle_oen", o_en, 0);
  endtask

  task automatic compare_q(input string tag);
    for (int n = 0; n < exp_q.size(); n++) begin
      check_val($sformatf("%s[%0d]", tag, n),
                (n < got.size()) ? 32'(got[n]) : 32'hFFFF_FFFF, 32'(exp_q[n]));
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_oen", o_en, 0);
    check_val("rst_ready", i_ready, 0);
    check_val("rst_odata", o_data, 0);
    @(negedge clk);
    check_val("rst_idle_ready", i_ready, 1);
  endtask

  task automatic run_xy(input string tag);
    blk   = {8'h58, 8'h59};
    exp_q = {8'h00, 8'h58, 8'h00, 8'h59};
    fork
      send_block(blk, 1'b1);
      collect(4, -1, 2000);
    join
    compare_q(tag);
  endtask

  initial begin
    int guard;
    rst = 1'b1; i_en = 1'b0; i_last = 1'b0; i_data = 8'h00; o_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_val("init_oen", o_en, 0);
    check_val("init_odata", o_data, 0);
    check_val("init_ready", i_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check_val("init_idle_ready", i_ready, 1);

    // Four distinct literals; i_en held with junk while busy must be ignored.
    blk   = {8'h41, 8'h42, 8'h43, 8'h44};
    exp_q = {8'h00, 8'h41, 8'h00, 8'h42, 8'h00, 8'h43, 8'h00, 8'h44};
    fork
      begin
        send_block(blk, 1'b1);
        i_en = 1'b1; i_data = 8'hEE;
        repeat (3) @(negedge clk);
        i_en = 1'b0;
      end
      collect(8, -1, 2000);
    join
    compare_q("lit4");

    blk = {};
    repeat (8) blk.push_back(8'h55);
    exp_q = {8'h00, 8'h55, 8'h27, 8'h00};
    fork
      send_block(blk, 1'b1);
      collect(4, -1, 2000);
    join
    compare_q("run55");

    blk = {};
    for (int r = 0; r < 2; r++)
      for (int n = 0; n < 10; n++) blk.push_back(8'(8'h41 + n));
    exp_q = {};
    for (int n = 0; n < 10; n++) begin
      exp_q.push_back(8'h00);
      exp_q.push_back(8'(8'h41 + n));
    end
    exp_q.push_back(8'h4A);
    exp_q.push_back(8'h01);
    fork
      send_block(blk, 1'b1);
      collect(22, -1, 5000);
    join
    compare_q("abc_x2");

    blk   = {8'h41, 8'h42, 8'h41, 8'h42};
    exp_q = {8'h00, 8'h41, 8'h00, 8'h42, 8'h00, 8'h41, 8'h00, 8'h42};
    fork
      send_block(blk, 1'b1);
      collect(8, -1, 2000);
    join
    compare_q("abab");

    blk = {};
    repeat (40) blk.push_back(8'h00);
    exp_q = {8'h00, 8'h00, 8'h3F, 8'h00, 8'h28, 8'h00};
    fork
      send_block(blk, 1'b1);
      collect(6, -1, 5000);
    join
    compare_q("zeros40");

    // Full 4096-byte ramp, no i_last; stall on the B byte of the first match token.
    blk = {};
    for (int n = 0; n < 4096; n++) blk.push_back(8'(n));
    exp_q = {};
    for (int n = 0; n < 256; n++) begin
      exp_q.push_back(8'h00);
      exp_q.push_back(8'(n));
    end
    for (int n = 0; n < 123; n++) begin
      exp_q.push_back(8'h1F);
      exp_q.push_back(8'h20);
    end
    exp_q.push_back(8'h1B);
    exp_q.push_back(8'h20);
    fork
      send_block(blk, 1'b0);
      collect(760, 513, 100000);
    join
    compare_q("ramp4096");

    // Reset while searching, before any token is out.
    blk = {8'h41, 8'h42, 8'h43, 8'h44};
    send_block(blk, 1'b1);
    check_val("pre_rst_search_oen", o_en, 0);
    reset_pulse();
    run_xy("xy_after_search_rst");

    // Reset in EMIT_B with the B byte stalled.
    blk = {8'h50, 8'h51};
    send_block(blk, 1'b1);
    guard = 0;
    while (!o_en && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_val("pre_emit_a_oen", o_en, 1);
    check_val("pre_emit_a_data", o_data, 8'h00);
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    check_val("pre_rst_emitb_oen", o_en, 1);
    check_val("pre_rst_emitb_data", o_data, 8'h50);
    reset_pulse();
    run_xy("xy_after_emitb_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
